// File: rtl/hamming_pkg.sv
// hamming_pkg
//   Shared definitions for the Hamming(15,11) + overall-parity SECDED code,
//   used by both the encoder and the decoder.
//   Codeword bit index i-1 holds position i (1..16). Position 16 is the overall
//   parity bit. Positions 1, 2, 4 and 8 are the Hamming check bits, and the
//   remaining positions carry data.
package hamming_pkg;

   localparam int unsigned CW_W   = 16;
   localparam int unsigned DATA_W = 11;
   localparam int unsigned SYN_W  = 4;

   // Parity bit positions
   localparam int unsigned P1  = 1;
   localparam int unsigned P2  = 2;
   localparam int unsigned P4  = 4;
   localparam int unsigned P8  = 8;
   localparam int unsigned P16 = 16;

   typedef enum logic [1:0] {
      DEC_CLEAN,   // no error
      DEC_SEC,     // single error in positions 1..15, corrected
      DEC_PAR,     // only the overall parity bit flipped
      DEC_DED      // double error, data left uncorrected
   } dec_kind_t;

   // Position (1..16) that carries data bit i
   function automatic int unsigned data_pos(input int unsigned i);
      case (i)
         0:       return 3;
         1:       return 5;
         2:       return 6;
         3:       return 7;
         default: return i + 5;   // data[4..10] -> positions 9..15
      endcase
   endfunction

   // Codeword mask of positions 1..15 that are covered by syndrome bit b
   function automatic logic [CW_W-1:0] syn_mask(input int unsigned b);
      logic [CW_W-1:0] m;
      int unsigned     pbit;
      m = '0;
      case (b)
         0:       pbit = P1;
         1:       pbit = P2;
         2:       pbit = P4;
         default: pbit = P8;
      endcase
      for (int unsigned pos = 1; pos < P16; pos++) begin
         if ((pos & pbit) != 0) m = m | (CW_W'(1) << (pos - 1));
      end
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
      return {cw[14:8], cw[6:4], cw[2]};
   endfunction

   function automatic dec_kind_t decode_kind(input logic [SYN_W-1:0] syn, input logic par);
      if (syn == '0) return par ? DEC_PAR : DEC_CLEAN;
      else           return par ? DEC_SEC : DEC_DED;
   endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome
//   Combinational syndrome and overall-parity generator.
//   Ports:
//     cw   in  16-bit codeword (bit i-1 = position i)
//     syn  out {s8,s4,s2,s1}; non-zero syndrome names the flipped position
//     par  out XOR of all 16 positions
module hamming_syndrome
   import hamming_pkg::*;
(
   input  logic [CW_W-1:0]  cw,
   output logic [SYN_W-1:0] syn,
   output logic             par
);

   always_comb begin
      syn[0] = ^(cw & syn_mask(0));
      syn[1] = ^(cw & syn_mask(1));
      syn[2] = ^(cw & syn_mask(2));
      syn[3] = ^(cw & syn_mask(3));
      par    = ^cw;
   end

endmodule

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder
//   Two-stage SECDED decoder with valid/ready handshake and saturating
//   SEC/DED event counters.
//   Ports:
//     clk, rst               clock (rising edge), async active-high reset
//     in_valid/in_ready      codeword handshake; in_cw is the codeword
//     out_valid/out_ready    result handshake
//     out_data               decoded (corrected where possible) data
//     out_sec/out_ded        single-corrected / double-detected flags
//     out_err_pos            corrected position 1..16, 0 if none or DED
//     cnt_clr                synchronous clear of both counters
//     sec_count/ded_count    saturating counts of transferred SEC/DED results
module hamming_secded_decoder
   import hamming_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_cw,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sec,
   output logic              out_ded,
   output logic [4:0]        out_err_pos,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  sec_count,
   output logic [CNT_W-1:0]  ded_count
);

   logic en;
   logic xfer;

   // The whole pipeline stalls only while a result waits on the consumer
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;
   assign xfer     = out_valid && out_ready;

   // Stage 1: capture codeword plus syndrome and parity
   logic [SYN_W-1:0] syn_c;
   logic             par_c;

   hamming_syndrome u_syndrome (
      .cw  (in_cw),
      .syn (syn_c),
      .par (par_c)
   );

   logic             s1_valid;
   logic [CW_W-1:0]  s1_cw;
   logic [SYN_W-1:0] s1_syn;
   logic             s1_par;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_cw    <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_cw  <= in_cw;
            s1_syn <= syn_c;
            s1_par <= par_c;
         end
      end
   end

   // Stage 2: classify, correct and extract data
   dec_kind_t        kind;
   logic [CW_W-1:0]  fixed_cw;
   logic             dec_sec;
   logic             dec_ded;
   logic [4:0]       dec_pos;

   always_comb begin
      kind     = decode_kind(s1_syn, s1_par);
      fixed_cw = s1_cw;
      dec_sec  = 1'b0;
      dec_ded  = 1'b0;
      dec_pos  = '0;
      unique case (kind)
         DEC_SEC: begin
            // Syndrome is the 1-based position, so bit index is syndrome-1
            fixed_cw = s1_cw ^ (CW_W'(1) << (s1_syn - 1'b1));
            dec_sec  = 1'b1;
            dec_pos  = {1'b0, s1_syn};
         end
         DEC_PAR: begin
            dec_sec = 1'b1;
            dec_pos = 5'(P16);
         end
         DEC_DED: begin
            dec_ded = 1'b1;
         end
         DEC_CLEAN: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_sec     <= 1'b0;
         out_ded     <= 1'b0;
         out_err_pos <= '0;
      end else if (en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data    <= extract_data(fixed_cw);
            out_sec     <= dec_sec;
            out_ded     <= dec_ded;
            out_err_pos <= dec_pos;
         end
      end
   end

   // Counters: count on transfer so a stalled result is counted once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_count <= '0;
         ded_count <= '0;
      end else if (cnt_clr) begin
         sec_count <= '0;
         ded_count <= '0;
      end else begin
         if (xfer && out_sec && (sec_count != '1)) sec_count <= sec_count + 1'b1;
         if (xfer && out_ded && (ded_count != '1)) ded_count <= ded_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb_hamming_secded_decoder
//   Directed bench for hamming_secded_decoder. Two instances share stimulus:
//   one with 16-bit counters, one with 2-bit counters for saturation.
module tb_hamming_secded_decoder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready, in_ready2;
   logic [15:0] in_cw;
   logic        out_valid, out_valid2;
   logic        out_ready;
   logic [10:0] out_data, out_data2;
   logic        out_sec, out_sec2;
   logic        out_ded, out_ded2;
   logic [4:0]  out_err_pos, out_err_pos2;
   logic        cnt_clr;
   logic [15:0] sec_count, ded_count;
   logic [1:0]  sec_count2, ded_count2;

   hamming_secded_decoder #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sec(out_sec), .out_ded(out_ded), .out_err_pos(out_err_pos),
      .cnt_clr(cnt_clr), .sec_count(sec_count), .ded_count(ded_count)
   );

   hamming_secded_decoder #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_cw(in_cw),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_sec(out_sec2), .out_ded(out_ded2), .out_err_pos(out_err_pos2),
      .cnt_clr(cnt_clr), .sec_count(sec_count2), .ded_count(ded_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [10:0] data;
      logic        sec;
      logic        ded;
      logic [4:0]  pos;
   } exp_t;

   localparam int DP [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

   exp_t        q[$];
   int unsigned m_sec, m_ded, m_sec2, m_ded2;
   exp_t        head;
   logic        x_sec, x_ded;

   // Reference decode: syndrome is the XOR of the indices of set positions
   function automatic exp_t model(input logic [15:0] cw);
      exp_t        r;
      int          s;
      int          p;
      logic [15:0] w;
      s = 0;
      p = 0;
      for (int i = 1; i <= 16; i++) begin
         if (cw[i-1]) begin
            p ^= 1;
            if (i < 16) s ^= i;
         end
      end
      w = cw;
      r = '0;
      if (s == 0 && p == 1) begin
         r.sec = 1'b1;
         r.pos = 5'd16;
      end else if (s != 0 && p == 1) begin
         w[s-1] = ~w[s-1];
         r.sec  = 1'b1;
         r.pos  = 5'(s);
      end else if (s != 0) begin
         r.ded = 1'b1;
      end
      for (int k = 0; k < 11; k++) r.data[k] = w[DP[k]-1];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input logic [15:0] cw);
      in_valid = 1'b1;
      in_cw    = cw;
      step();
      in_valid = 1'b0;
      step();
   endtask

   // Model bookkeeping at each clock edge (and on async reset)
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_sec  = 0;
         m_ded  = 0;
         m_sec2 = 0;
         m_ded2 = 0;
      end else begin
         x_sec = 1'b0;
         x_ded = 1'b0;
         if (out_valid && out_ready && q.size() > 0) begin
            head  = q.pop_front();
            x_sec = head.sec;
            x_ded = head.ded;
         end
         if (in_valid && in_ready) q.push_back(model(in_cw));
         if (cnt_clr) begin
            m_sec  = 0;
            m_ded  = 0;
            m_sec2 = 0;
            m_ded2 = 0;
         end else begin
            if (x_sec && m_sec  < 65535) m_sec++;
            if (x_ded && m_ded  < 65535) m_ded++;
            if (x_sec && m_sec2 < 3)     m_sec2++;
            if (x_ded && m_ded2 < 3)     m_ded2++;
         end
      end
   end

   // Compare process, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               chk("out_data",    32'(out_data),    32'(q[0].data));
               chk("out_sec",     32'(out_sec),     32'(q[0].sec));
               chk("out_ded",     32'(out_ded),     32'(q[0].ded));
               chk("out_err_pos", 32'(out_err_pos), 32'(q[0].pos));
            end
         end
         if (out_valid2 && q.size() > 0) chk("out_data2", 32'(out_data2), 32'(q[0].data));
         chk("sec_count",  32'(sec_count),  m_sec);
         chk("ded_count",  32'(ded_count),  m_ded);
         chk("sec_count2", 32'(sec_count2), m_sec2);
         chk("ded_count2", 32'(ded_count2), m_ded2);
      end
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_cw     = '0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;

      // Pin the model with hand-computed values
      chk("model_8017_data", 32'(model(16'h8017).data), 32'h001);
      chk("model_8017_pos",  32'(model(16'h8017).pos),  32'd5);
      chk("model_8000_pos",  32'(model(16'h8000).pos),  32'd16);
      chk("model_0014_ded",  32'(model(16'h0014).ded),  32'd1);
      chk("model_0014_data", 32'(model(16'h0014).data), 32'h003);
      chk("model_ffff_data", 32'(model(16'hFFFF).data), 32'h7FF);

      step();
      step();
      chk("rst_out_valid", 32'(out_valid),   32'd0);
      chk("rst_out_data",  32'(out_data),    32'd0);
      chk("rst_out_sec",   32'(out_sec),     32'd0);
      chk("rst_out_ded",   32'(out_ded),     32'd0);
      chk("rst_out_pos",   32'(out_err_pos), 32'd0);
      chk("rst_sec_count", 32'(sec_count),   32'd0);
      chk("rst_ded_count", 32'(ded_count),   32'd0);
      rst = 1'b0;
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);

      // Clean words back-to-back, fixed latency
      in_valid = 1'b1;
      in_cw    = 16'h0000;
      step();
      chk("lat_w0_not_yet", 32'(out_valid), 32'd0);
      in_cw = 16'hFFFF;
      step();
      chk("clean0_valid", 32'(out_valid), 32'd1);
      chk("clean0_data",  32'(out_data),  32'h000);
      in_cw = 16'h8007;
      step();
      chk("clean1_data", 32'(out_data), 32'h7FF);
      in_valid = 1'b0;
      step();
      chk("clean2_data", 32'(out_data),    32'h001);
      chk("clean2_sec",  32'(out_sec),     32'd0);
      chk("clean2_ded",  32'(out_ded),     32'd0);
      chk("clean2_pos",  32'(out_err_pos), 32'd0);
      step();
      chk("clean_drained", 32'(out_valid), 32'd0);

      // Single error at position 5
      send1(16'h8017);
      chk("sec_data", 32'(out_data),    32'h001);
      chk("sec_flag", 32'(out_sec),     32'd1);
      chk("sec_pos",  32'(out_err_pos), 32'd5);
      step();
      chk("sec_cnt1", 32'(sec_count), 32'd1);

      // Parity-only error, then double error
      send1(16'h8000);
      chk("par_data", 32'(out_data),    32'h000);
      chk("par_sec",  32'(out_sec),     32'd1);
      chk("par_pos",  32'(out_err_pos), 32'd16);
      step();
      send1(16'h0014);
      chk("ded_flag", 32'(out_ded),     32'd1);
      chk("ded_sec",  32'(out_sec),     32'd0);
      chk("ded_pos",  32'(out_err_pos), 32'd0);
      chk("ded_data", 32'(out_data),    32'h003);
      step();
      chk("ded_cnt1", 32'(ded_count), 32'd1);
      chk("sec_cnt2", 32'(sec_count), 32'd2);

      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_sec", 32'(sec_count), 32'd0);
      chk("clr_ded", 32'(ded_count), 32'd0);

      // Backpressure: two words in the pipe, a third waiting
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_cw     = 16'h8017;
      step();
      in_cw = 16'h0000;
      step();
      in_cw = 16'h0014;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready",  32'(in_ready),    32'd0);
         chk("bp_out_valid", 32'(out_valid),   32'd1);
         chk("bp_out_data",  32'(out_data),    32'h001);
         chk("bp_out_pos",   32'(out_err_pos), 32'd5);
         step();
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("bp_w2_data", 32'(out_data), 32'h000);
      chk("bp_w2_sec",  32'(out_sec),  32'd0);
      step();
      chk("bp_w3_ded",  32'(out_ded),  32'd1);
      chk("bp_w3_data", 32'(out_data), 32'h003);
      step();
      chk("bp_drained", 32'(out_valid), 32'd0);
      chk("bp_sec_cnt", 32'(sec_count), 32'd1);
      chk("bp_ded_cnt", 32'(ded_count), 32'd1);

      // Saturation of the 2-bit counter
      cnt_clr = 1'b1;
      step();
      cnt_clr  = 1'b0;
      in_valid = 1'b1;
      in_cw    = 16'h8017;
      repeat (5) step();
      in_valid = 1'b0;
      repeat (3) step();
      chk("sat_sec2", 32'(sec_count2), 32'd3);
      chk("sat_sec",  32'(sec_count),  32'd5);

      // Clear wins over a same-cycle SEC transfer
      send1(16'h8017);
      chk("clr_race_valid", 32'(out_valid), 32'd1);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_race_sec",  32'(sec_count),  32'd0);
      chk("clr_race_sec2", 32'(sec_count2), 32'd0);
      chk("clr_race_xfer", 32'(out_valid),  32'd0);

      // Asynchronous reset mid-stream
      in_valid = 1'b1;
      in_cw    = 16'h8017;
      repeat (3) step();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_sec_count", 32'(sec_count), 32'd0);
      chk("arst_ded_count", 32'(ded_count), 32'd0);
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_idle", 32'(out_valid), 32'd0);
      end
      send1(16'hFFFF);
      chk("post_rst_data", 32'(out_data), 32'h7FF);
      step();
      repeat (2) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
